// File: rtl/kb_pkg.sv
// Shared constants for the PS/2 key event queue: prefix bytes, modifier
// scancodes, decoder state encoding and event field layout.
package kb_pkg;

   localparam logic [7:0] KB_E0 = 8'hE0;
   localparam logic [7:0] KB_E1 = 8'hE1;
   localparam logic [7:0] KB_F0 = 8'hF0;
   localparam logic [7:0] KB_AA = 8'hAA;
   localparam logic [7:0] KB_FA = 8'hFA;
   localparam logic [7:0] KB_EE = 8'hEE;
   localparam logic [7:0] KB_FE = 8'hFE;
   localparam logic [7:0] KB_FF = 8'hFF;
   localparam logic [7:0] KB_00 = 8'h00;

   localparam logic [7:0] KB_LSHIFT = 8'h12;
   localparam logic [7:0] KB_RSHIFT = 8'h59;
   localparam logic [7:0] KB_CTRL   = 8'h14;
   localparam logic [7:0] KB_ALT    = 8'h11;

   localparam int KB_EVENT_W  = 10;
   localparam int KB_BRK_BIT  = 9;
   localparam int KB_EXT_BIT  = 8;
   localparam int KB_CODE_MSB = 7;
   localparam int KB_CODE_LSB = 0;

   typedef logic [2:0] kb_state_t;
   localparam kb_state_t S_IDLE    = 3'd0;
   localparam kb_state_t S_EXT     = 3'd1;
   localparam kb_state_t S_BRK     = 3'd2;
   localparam kb_state_t S_EXT_BRK = 3'd3;
   localparam kb_state_t S_E1      = 3'd4;

   // Controller acknowledge/status bytes that carry no key information.
   function automatic logic kb_is_filler(input logic [7:0] b);
      return (b == KB_00) || (b == KB_AA) || (b == KB_EE) ||
             (b == KB_FA) || (b == KB_FE) || (b == KB_FF);
   endfunction

   function automatic logic kb_is_shift(input logic [7:0] b);
      return (b == KB_LSHIFT) || (b == KB_RSHIFT);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO with occupancy count, full flag and sticky overflow.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             ovf_clr,
   output logic             valid,
   output logic [WIDTH-1:0] head,
   output logic [AW:0]      count,
   output logic             full,
   output logic             overflow
);

   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             overflow_reg;
   logic             pop_ok;
   logic             push_ok;
   logic             drop;

   // Pointers carry an extra MSB so full and empty stay distinguishable.
   assign count    = wr_ptr_reg - rd_ptr_reg;
   assign valid    = (count != '0);
   assign full     = (count == DEPTH_CNT);
   assign pop_ok   = pop & valid;
   assign push_ok  = push & (~full | pop_ok);
   assign drop     = push & full & ~pop_ok;
   assign head     = valid ? mem[rd_ptr_reg[AW-1:0]] : '0;
   assign overflow = overflow_reg;

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (drop)
            overflow_reg <= 1'b1;
         else if (ovf_clr)
            overflow_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/kb_event_queue.sv
// PS/2 byte decoder feeding a key event FIFO, with modifier tracking.
// Optional typematic repeat suppression: define KB_TYPEMATIC_FILTER_EN.
module kb_event_queue
   import kb_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_sclr,
   input  logic                  i_byte_en,
   input  logic [7:0]            i_byte,
   input  logic                  i_pop,
   input  logic                  i_ovf_clr,
   output logic                  o_valid,
   output logic [KB_EVENT_W-1:0] o_event,
   output logic [AW:0]           o_count,
   output logic                  o_full,
   output logic                  o_overflow,
   output logic                  o_shift,
   output logic                  o_ctrl,
   output logic                  o_alt
);

   kb_state_t       state_reg, state_next;
   logic [2:0]      skip_reg, skip_next;
   logic            emit;
   logic            ev_brk;
   logic            ev_ext;
   logic [7:0]      ev_code;
   logic            accept;
   logic            shift_reg, ctrl_reg, alt_reg;
   logic [KB_EVENT_W-1:0] ev_word;

   always_comb begin
      state_next = state_reg;
      skip_next  = skip_reg;
      emit       = 1'b0;
      ev_brk     = 1'b0;
      ev_ext     = 1'b0;
      if (i_byte_en) begin
         case (state_reg)
            S_IDLE: begin
               if (i_byte == KB_E0)
                  state_next = S_EXT;
               else if (i_byte == KB_F0)
                  state_next = S_BRK;
               else if (i_byte == KB_E1) begin
                  state_next = S_E1;
                  skip_next  = 3'd7;
               end else if (!kb_is_filler(i_byte))
                  emit = 1'b1;
            end
            S_EXT: begin
               if (i_byte == KB_F0)
                  state_next = S_EXT_BRK;
               else begin
                  state_next = S_IDLE;
                  emit       = !kb_is_shift(i_byte);
                  ev_ext     = 1'b1;
               end
            end
            S_BRK: begin
               state_next = S_IDLE;
               emit       = 1'b1;
               ev_brk     = 1'b1;
            end
            S_EXT_BRK: begin
               state_next = S_IDLE;
               emit       = !kb_is_shift(i_byte);
               ev_brk     = 1'b1;
               ev_ext     = 1'b1;
            end
            S_E1: begin
               // Pause bytes are swallowed; the last one yields a single event.
               skip_next = skip_reg - 3'd1;
               if (skip_reg == 3'd1) begin
                  state_next = S_IDLE;
                  emit       = 1'b1;
                  ev_ext     = 1'b1;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   assign ev_code = (state_reg == S_E1) ? KB_E1 : i_byte;
   assign ev_word = {ev_brk, ev_ext, ev_code};

`ifdef KB_TYPEMATIC_FILTER_EN
   logic       held_reg;
   logic [8:0] held_key_reg;
   logic       repeat_make;

   assign repeat_make = emit & ~ev_brk & held_reg & (held_key_reg == {ev_ext, ev_code});
   assign accept      = emit & ~repeat_make;

   always_ff @(posedge clk or posedge i_sclr) begin
      if (i_sclr) begin
         held_reg     <= 1'b0;
         held_key_reg <= '0;
      end else if (accept) begin
         if (!ev_brk) begin
            held_reg     <= 1'b1;
            held_key_reg <= {ev_ext, ev_code};
         end else if (held_key_reg == {ev_ext, ev_code})
            held_reg <= 1'b0;
      end
   end
`else
   assign accept = emit;
`endif

   always_ff @(posedge clk or posedge i_sclr) begin
      if (i_sclr) begin
         state_reg <= S_IDLE;
         skip_reg  <= '0;
         shift_reg <= 1'b0;
         ctrl_reg  <= 1'b0;
         alt_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         skip_reg  <= skip_next;
         if (accept) begin
            if (!ev_ext && kb_is_shift(ev_code))
               shift_reg <= ~ev_brk;
            if (ev_code == KB_CTRL)
               ctrl_reg <= ~ev_brk;
            if (ev_code == KB_ALT)
               alt_reg <= ~ev_brk;
         end
      end
   end

   assign o_shift = shift_reg;
   assign o_ctrl  = ctrl_reg;
   assign o_alt   = alt_reg;

   sync_fifo #(
      .WIDTH (KB_EVENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (i_sclr),
      .push      (accept),
      .push_data (ev_word),
      .pop       (i_pop),
      .ovf_clr   (i_ovf_clr),
      .valid     (o_valid),
      .head      (o_event),
      .count     (o_count),
      .full      (o_full),
      .overflow  (o_overflow)
   );

endmodule

// File: tb/tb_kb_event_queue.sv
// Self-checking bench for kb_event_queue against a prefix-flag reference model.
module tb_kb_event_queue;

   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);
   localparam int SW    = AW + 17;

   logic          clk = 1'b0;
   logic          i_sclr = 1'b1;
   logic          i_byte_en = 1'b0;
   logic [7:0]    i_byte = 8'h00;
   logic          i_pop = 1'b0;
   logic          i_ovf_clr = 1'b0;
   logic          o_valid;
   logic [9:0]    o_event;
   logic [AW:0]   o_count;
   logic          o_full;
   logic          o_overflow;
   logic          o_shift, o_ctrl, o_alt;

   int compared   = 0;
   int mismatched = 0;

   kb_event_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .i_sclr     (i_sclr),
      .i_byte_en  (i_byte_en),
      .i_byte     (i_byte),
      .i_pop      (i_pop),
      .i_ovf_clr  (i_ovf_clr),
      .o_valid    (o_valid),
      .o_event    (o_event),
      .o_count    (o_count),
      .o_full     (o_full),
      .o_overflow (o_overflow),
      .o_shift    (o_shift),
      .o_ctrl     (o_ctrl),
      .o_alt      (o_alt)
   );

   always #5 clk = ~clk;

   logic [SW-1:0] dut_status;
   assign dut_status = {o_valid, o_event, o_count, o_full, o_overflow, o_shift, o_ctrl, o_alt};

   // Reference model: queue of events plus prefix flags and a pause countdown.
   logic [9:0] mq[$];
   logic       m_ovf, m_shift, m_ctrl, m_alt, m_ext, m_brk, m_held;
   logic [8:0] m_held_key;
   int         pause_left;

   task automatic model_reset();
      mq.delete();
      m_ovf = 0; m_shift = 0; m_ctrl = 0; m_alt = 0;
      m_ext = 0; m_brk = 0; m_held = 0; m_held_key = '0;
      pause_left = 0;
   endtask

   function automatic logic [SW-1:0] exp_status();
      logic [9:0] h;
      h = (mq.size() > 0) ? mq[0] : 10'h000;
      return {mq.size() > 0, h, (AW+1)'(mq.size()), mq.size() == DEPTH, m_ovf, m_shift, m_ctrl, m_alt};
   endfunction

   function automatic logic fake_shift(input logic [7:0] b);
      return (b == 8'h12) || (b == 8'h59);
   endfunction

   task automatic model_emit(input logic brk, input logic ext, input logic [7:0] code,
                             output logic push, output logic [9:0] ev);
      push = 1'b1;
      ev   = {brk, ext, code};
`ifdef KB_TYPEMATIC_FILTER_EN
      if (!brk && m_held && m_held_key == {ext, code}) begin
         push = 1'b0;
         return;
      end
      if (!brk) begin
         m_held = 1'b1;
         m_held_key = {ext, code};
      end else if (m_held && m_held_key == {ext, code})
         m_held = 1'b0;
`endif
      if (!ext && fake_shift(code)) m_shift = !brk;
      if (code == 8'h14) m_ctrl = !brk;
      if (code == 8'h11) m_alt = !brk;
   endtask

   task automatic model_decode(input logic [7:0] b, output logic push, output logic [9:0] ev);
      push = 1'b0;
      ev   = 10'h000;
      if (pause_left > 0) begin
         pause_left--;
         if (pause_left == 0) model_emit(1'b0, 1'b1, 8'hE1, push, ev);
      end else if (m_brk) begin
         if (!(m_ext && fake_shift(b))) model_emit(1'b1, m_ext, b, push, ev);
         m_brk = 0;
         m_ext = 0;
      end else if (m_ext) begin
         if (b == 8'hF0) m_brk = 1;
         else begin
            if (!fake_shift(b)) model_emit(1'b0, 1'b1, b, push, ev);
            m_ext = 0;
         end
      end else begin
         case (b)
            8'hE0: m_ext = 1;
            8'hF0: m_brk = 1;
            8'hE1: pause_left = 7;
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
            default: model_emit(1'b0, 1'b0, b, push, ev);
         endcase
      end
   endtask

   task automatic model_step(input logic en, input logic [7:0] b, input logic pop, input logic clr);
      logic push, pop_ok, set_ovf;
      logic [9:0] ev;
      push = 1'b0;
      ev = 10'h000;
      if (en) model_decode(b, push, ev);
      pop_ok  = pop && (mq.size() > 0);
      set_ovf = push && (mq.size() == DEPTH) && !pop_ok;
      if (pop_ok) void'(mq.pop_front());
      if (push && !set_ovf) mq.push_back(ev);
      if (set_ovf) m_ovf = 1;
      else if (clr) m_ovf = 0;
   endtask

   // One clock: inputs applied from a falling edge, results observed at the next one.
   task automatic step(input logic en, input logic [7:0] b, input logic pop, input logic clr);
      i_byte_en = en; i_byte = b; i_pop = pop; i_ovf_clr = clr;
      @(posedge clk);
      model_step(en, b, pop, clr);
      @(negedge clk);
      i_byte_en = 0; i_pop = 0; i_ovf_clr = 0;
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic drain();
      int n;
      n = mq.size();
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      #2 i_sclr = 1'b1;
      model_reset();
      @(negedge clk);
      i_sclr = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(negedge clk);
      if (dut_status !== '0) begin
         mismatched++;
         $display("FAIL reset_state: got %h want 0", dut_status);
      end
      compared++;
      i_sclr = 1'b0;
   endtask

   task automatic test_make_break();
      send(8'h1C); send(8'hF0); send(8'h1C);
      if (o_count !== 4'd2 || o_event !== 10'h01C) begin
         mismatched++;
         $display("FAIL make_break_head: count %0d event %h want 2 01c", o_count, o_event);
      end
      compared++;
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (o_event !== 10'h21C) begin
         mismatched++;
         $display("FAIL make_break_second: event %h want 21c", o_event);
      end
      compared++;
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (o_valid !== 1'b0 || dut_status !== exp_status()) begin
         mismatched++;
         $display("FAIL make_break_empty: got %h want %h", dut_status, exp_status());
      end
      compared++;
   endtask

   task automatic test_extended();
      logic [7:0] seq [10] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12, 8'hE0, 8'hF0, 8'h12};
      foreach (seq[i]) send(seq[i]);
      if (o_count !== 4'd2 || o_event !== 10'h175) begin
         mismatched++;
         $display("FAIL ext_head: count %0d event %h want 2 175", o_count, o_event);
      end
      compared++;
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (o_event !== 10'h375 || o_count !== 4'd1) begin
         mismatched++;
         $display("FAIL ext_break: count %0d event %h want 1 375", o_count, o_event);
      end
      compared++;
      drain();
   endtask

   task automatic test_pause();
      logic [7:0] seq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
      foreach (seq[i]) send(seq[i]);
      if (o_count !== 4'd2 || o_event !== 10'h1E1 || o_ctrl !== 1'b0) begin
         mismatched++;
         $display("FAIL pause_event: count %0d event %h ctrl %b want 2 1e1 0", o_count, o_event, o_ctrl);
      end
      compared++;
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (o_event !== 10'h01C) begin
         mismatched++;
         $display("FAIL pause_next: event %h want 01c", o_event);
      end
      compared++;
      drain();
   endtask

   task automatic test_modifiers();
      send(8'h12);
      if (o_shift !== 1'b1) begin
         mismatched++;
         $display("FAIL shift_set: got %b want 1", o_shift);
      end
      compared++;
      send(8'hF0); send(8'h12);
      if (o_shift !== 1'b0) begin
         mismatched++;
         $display("FAIL shift_clr: got %b want 0", o_shift);
      end
      compared++;
      send(8'h14);
      if (o_ctrl !== 1'b1) begin
         mismatched++;
         $display("FAIL ctrl_set: got %b want 1", o_ctrl);
      end
      compared++;
      send(8'hE0); send(8'hF0); send(8'h14);
      if (o_ctrl !== 1'b0 || dut_status !== exp_status()) begin
         mismatched++;
         $display("FAIL ctrl_clr: got %h want %h", dut_status, exp_status());
      end
      compared++;
      drain();
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i <= DEPTH; i++) send(8'h20 + 8'(i));
      if (o_full !== 1'b1 || o_overflow !== 1'b1 || o_event !== 10'h020 || o_count !== (AW+1)'(DEPTH)) begin
         mismatched++;
         $display("FAIL overflow_set: full %b ovf %b event %h count %0d want 1 1 020 %0d",
                  o_full, o_overflow, o_event, o_count, DEPTH);
      end
      compared++;
      step(1'b0, 8'h00, 1'b0, 1'b1);
      if (o_overflow !== 1'b0) begin
         mismatched++;
         $display("FAIL overflow_clr: got %b want 0", o_overflow);
      end
      compared++;
      step(1'b1, 8'h30, 1'b1, 1'b0);
      if (o_count !== (AW+1)'(DEPTH) || o_event !== 10'h021 || o_overflow !== 1'b0) begin
         mismatched++;
         $display("FAIL push_pop_full: count %0d event %h ovf %b want %0d 021 0", o_count, o_event, o_overflow, DEPTH);
      end
      compared++;
      // Set and clear in the same cycle: set wins.
      step(1'b1, 8'h31, 1'b0, 1'b1);
      if (o_overflow !== 1'b1 || dut_status !== exp_status()) begin
         mismatched++;
         $display("FAIL ovf_priority: got %h want %h", dut_status, exp_status());
      end
      compared++;
      drain();
      step(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_reset_midseq();
      send(8'hE0);
      #2 i_sclr = 1'b1;
      #1;
      model_reset();
      if (dut_status !== '0) begin
         mismatched++;
         $display("FAIL async_reset: got %h want 0", dut_status);
      end
      compared++;
      @(negedge clk);
      i_sclr = 1'b0;
      send(8'h1C);
      if (o_event !== 10'h01C) begin
         mismatched++;
         $display("FAIL reset_midseq: event %h want 01c", o_event);
      end
      compared++;
      drain();
   endtask

   task automatic test_typematic();
      int want;
`ifdef KB_TYPEMATIC_FILTER_EN
      want = 2;
`else
      want = 4;
`endif
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
      if (int'(o_count) != want || o_event !== 10'h01C || dut_status !== exp_status()) begin
         mismatched++;
         $display("FAIL typematic: count %0d event %h want %0d 01c", o_count, o_event, want);
      end
      compared++;
      drain();
   endtask

   task automatic test_random();
      logic [7:0] pool [16] = '{8'hE0, 8'hE1, 8'hF0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h11,
                                8'h1C, 8'h75, 8'hAA, 8'h00, 8'hFA, 8'h1C, 8'h2B, 8'h33};
      logic en, pop, clr;
      logic [7:0] b;
      for (int i = 0; i < 800; i++) begin
         en  = ($urandom_range(0, 3) != 0);
         pop = ($urandom_range(0, 2) == 0);
         clr = ($urandom_range(0, 15) == 0);
         b   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
         step(en, b, pop, clr);
         if (dut_status !== exp_status()) begin
            mismatched++;
            $display("FAIL random_%0d: byte %h got %h want %h", i, b, dut_status, exp_status());
         end
         compared++;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 24; i++) begin
         step(1'b1, (i % 2 == 0) ? 8'h4D : 8'hF0, 1'b1, 1'b0);
         if (dut_status !== exp_status()) begin
            mismatched++;
            $display("FAIL back_to_back_%0d: got %h want %h", i, dut_status, exp_status());
         end
         compared++;
      end
      drain();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_make_break();
      test_extended();
      test_pause();
      test_modifiers();
      test_overflow();
      test_reset_midseq();
      test_typematic();
      test_back_to_back();
      do_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/kb_event_queue.md
Name: kb_event_queue

Overview:
- Parametrised successor to the single-byte keydown/shift decode path.
- Consumes raw PS/2 bytes from recv (i_byte_en/i_byte).
- Decodes make/break/extended/pause prefix sequences into 10-bit key events and tracks modifier state.
- Buffers events in a show-ahead FIFO of DEPTH entries, so a slow consumer (ascii converter, soft CPU) loses no keystrokes.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
AW, $clog2(DEPTH), derived FIFO address width; not for override

Ports:
clk  in  1  system clock
i_sclr  in  1  asynchronous active-high reset
i_byte_en  in  1  one-cycle strobe: i_byte is a complete received byte
i_byte  in  8  received PS/2 byte
i_pop  in  1  consumer takes the head event this cycle
i_ovf_clr  in  1  clears o_overflow
o_valid  out  1  FIFO non-empty; o_event is valid
o_event  out  10  head event {brk, ext, code[7:0]}
o_count  out  AW+1  number of stored events, 0..DEPTH
o_full  out  1  o_count == DEPTH
o_overflow  out  1  sticky: an event was dropped because the FIFO was full
o_shift, o_ctrl, o_alt  out  1 each  current modifier held state

Behaviour:
- Reset (async, any time, mid-sequence included):
  - FSM -> S_IDLE; FIFO emptied; skip counter cleared.
  - All outputs 0; o_event = 10'h000.
- Decoder FSM advances only on i_byte_en.
- S_IDLE:
  - E0 -> S_EXT; F0 -> S_BRK; E1 -> S_E1 with skip counter = 7.
  - 00, AA, EE, FA, FE, FF: dropped, stay in S_IDLE.
  - Any other byte: emit {0,0,byte}.
- S_EXT:
  - F0 -> S_EXT_BRK.
  - 12 or 59 (fake shift): drop, -> S_IDLE.
  - Any other byte: emit {0,1,byte}, -> S_IDLE.
- S_BRK: any byte: emit {1,0,byte}, -> S_IDLE.
- S_EXT_BRK:
  - 12 or 59: drop, -> S_IDLE.
  - Any other byte: emit {1,1,byte}, -> S_IDLE.
- S_E1 (Pause):
  - Each byte decrements the skip counter.
  - When it reaches 0: emit {0,1,8'hE1} once, -> S_IDLE.
  - Bytes inside the sequence are never decoded.
- Latency: event pushed on the clk edge that samples i_byte_en for the final byte; o_valid/o_event/o_count reflect it the next cycle.
- Modifiers: updated on every emitted event (including dropped-on-full).
  - brk=0 sets the modifier, brk=1 clears it.
  - shift = code 12 or 59 (ext=0).
  - ctrl = code 14 (either ext).
  - alt = code 11 (either ext).
- FIFO, show-ahead: o_event = head entry whenever o_valid=1.
  - i_pop with o_valid=0: ignored, no pointer change.
  - Push with full and no pop: event dropped, o_overflow <= 1, count stays DEPTH.
  - Push and pop in the same cycle when full: both accepted, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only.
  - Pointers wrap modulo DEPTH; o_count computed as write-read with an extra MSB.
- o_overflow: set has priority over i_ovf_clr in the same cycle.

Optional Feature:
- Macro: KB_TYPEMATIC_FILTER_EN.
- Defined:
  - A register holds the last make event {ext,code} plus a held flag.
  - A make identical to the held key is suppressed: no push, modifiers unchanged.
  - The matching break clears held; a different make replaces the held key.
- Undefined: every typematic repeat make is queued as a new event.

Decomposition:
- Package kb_pkg holds:
  - Prefix/control byte constants (E0, E1, F0, AA, FA, EE, FE).
  - Modifier scancodes (12, 59, 14, 11).
  - FSM state enum.
  - KB_EVENT_W = 10 and event field positions.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) contains storage, pointers, count, full and overflow.
- kb_event_queue keeps the decoder FSM, modifier registers and optional filter.

Test Plan:
- 1C, F0 1C -> events 0x01C then 0x21C; o_count 2; after two i_pop, o_valid=0.
- E0 75, E0 F0 75 -> 0x175 then 0x375; E0 12 and E0 F0 12 produce no events.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x1E1; the next byte 1C decodes normally to 0x01C.
- 12 (shift make) -> o_shift=1 one cycle after byte_en; F0 12 -> o_shift=0; 14, then E0 F0 14 -> o_ctrl=1 then 0.
- DEPTH+1 makes with no pop -> o_full=1, o_overflow=1, head still the first event; push with simultaneous pop at full -> count DEPTH, contents shifted, no new overflow; i_ovf_clr clears it.
- Reset asserted after E0 mid-sequence, then 1C -> event 0x01C (not 0x11C); with KB_TYPEMATIC_FILTER_EN, 1C 1C 1C F0 1C -> only 0x01C and 0x21C.
